// File: rtl/pipe_skid_buffer.sv
// Valid/ready pipeline stage with a main and a skid entry so in_ready is fully registered.
// Optional saturating stall counter on output stall_count, enabled by PIPE_STALL_CNT_EN.
module pipe_skid_buffer #(
    parameter int unsigned WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]            stall_count
`endif
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_LENGTH-1:0] main_q, main_d;
    logic [WORD_LENGTH-1:0] skid_q, skid_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   accept_c;
    logic                   take_c;

    assign accept_c  = in_valid & in_ready_q;
    assign take_c    = out_valid_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    // State and storage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next state and next register values; flush squashes both entries and drops any offer.
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        if (flush) begin
            state_d     = EMPTY;
            main_d      = '0;
            skid_d      = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        main_d      = in_data;
                        state_d     = BUSY;
                        out_valid_d = 1'b1;
                    end
                end
                BUSY: begin
                    if (accept_c && take_c) begin
                        main_d = in_data;
                    end else if (accept_c) begin
                        skid_d     = in_data;
                        state_d    = FULL;
                        in_ready_d = 1'b0;
                    end else if (take_c) begin
                        state_d     = EMPTY;
                        out_valid_d = 1'b0;
                    end
                end
                FULL: begin
                    if (take_c) begin
                        main_d     = skid_q;
                        state_d    = BUSY;
                        in_ready_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating stall counter; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: queue-based reference model, directed pins and random traffic.
module tb_pipe_skid_buffer;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0]  stall_count;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    pipe_skid_buffer #(.WORD_LENGTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a FIFO of at most two words, emptied by reset or flush.
    logic [W-1:0] q[$];
    bit           exp_zero = 1'b1;
    logic [31:0]  exp_cnt  = '0;

    always @(posedge clk) begin
        bit acc;
        bit tk;
        acc = in_valid && (q.size() < 2);
        tk  = (q.size() > 0) && out_ready;
        if (reset) begin
            q.delete();
            exp_zero = 1'b1;
            exp_cnt  = '0;
        end else begin
            if ((q.size() > 0) && !out_ready && (exp_cnt != 32'hFFFF_FFFF))
                exp_cnt = exp_cnt + 32'd1;
            if (flush) begin
                q.delete();
                exp_zero = 1'b1;
            end else begin
                if (tk) void'(q.pop_front());
                if (acc) begin
                    q.push_back(in_data);
                    exp_zero = 1'b0;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out_valid", 32'(out_valid), 32'(q.size() > 0));
            check("model_in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0)
                check("model_out_data", out_data, q[0]);
            else if (exp_zero)
                check("model_out_data_clr", out_data, 32'd0);
`ifdef PIPE_STALL_CNT_EN
            check("model_stall_count", stall_count, exp_cnt);
`endif
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f, input logic rst);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        reset     = rst;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        edge_sample();
        edge_sample();
        chk_en = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", out_data, 32'd0);

        // Streaming at full rate.
        drive(1'b1, 32'h11, 1'b1, 1'b0, 1'b0); edge_sample();
        check("stream_0x11", out_data, 32'h11);
        check("stream_valid", 32'(out_valid), 32'd1);
        drive(1'b1, 32'h22, 1'b1, 1'b0, 1'b0); edge_sample();
        check("stream_0x22", out_data, 32'h22);
        check("stream_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h33, 1'b1, 1'b0, 1'b0); edge_sample();
        check("stream_0x33", out_data, 32'h33);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); edge_sample();
        check("stream_drain", 32'(out_valid), 32'd0);

        // Back-pressure fills the skid entry.
        drive(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0); edge_sample();
        check("bp_first", out_data, 32'hA5);
        drive(1'b1, 32'h5A, 1'b0, 1'b0, 1'b0); edge_sample();
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold_a5", out_data, 32'hA5);
        drive(1'b1, 32'hFF, 1'b0, 1'b0, 1'b0); edge_sample();
        check("bp_ff_rejected", out_data, 32'hA5);
        check("bp_still_full", 32'(in_ready), 32'd0);
        drive(1'b1, 32'hFF, 1'b1, 1'b0, 1'b0); edge_sample();
        check("bp_then_5a", out_data, 32'h5A);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        drive(1'b1, 32'hFF, 1'b1, 1'b0, 1'b0); edge_sample();
        check("bp_then_ff", out_data, 32'hFF);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); edge_sample();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Flush while full, with a word offered in the same cycle.
        drive(1'b1, 32'h01, 1'b0, 1'b0, 1'b0); edge_sample();
        drive(1'b1, 32'h02, 1'b0, 1'b0, 1'b0); edge_sample();
        check("fl_full", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h77, 1'b0, 1'b1, 1'b0); edge_sample();
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        check("fl_out_data", out_data, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); edge_sample();
        check("fl_77_dropped", 32'(out_valid), 32'd0);

        // Reset while holding a word.
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0); edge_sample();
        check("rb_loaded", out_data, 32'hDEADBEEF);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); edge_sample();
        check("rb_out_valid", 32'(out_valid), 32'd0);
        check("rb_out_data", out_data, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); edge_sample();
        edge_sample();
        check("rb_no_emit", 32'(out_valid), 32'd0);

`ifdef PIPE_STALL_CNT_EN
        check("sc_after_reset", stall_count, 32'd0);
        drive(1'b1, 32'h1, 1'b0, 1'b0, 1'b0); edge_sample();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) edge_sample();
        check("sc_five", stall_count, 32'd5);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0); edge_sample();
        check("sc_flush_keeps", stall_count, 32'd5);
`endif

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0,
                  ($urandom % 40) == 0, ($urandom % 150) == 0);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        edge_sample();
        edge_sample();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
